// File: rtl/ctrl_wei.sv
// ctrl_wei: weight-fetch controller sitting in front of the weight distributor.
// It primes the distributor pipeline with discarded fetch pulses, then for each
// weight block it issues a fetch, waits for the distributor's ready flag and
// offers the block to the PE-cluster array for NumRep handshakes.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   TOP_Start            start-of-layer pulse (accepted only when idle)
//   TOP_NumBlk/NumRep    layer configuration, latched on an accepted start
//   DISWEI_RdyWei        distributor output holds valid weights
//   PEC_ReqWei           PEC array consumes the current weight set
//   CTRLWEI_PlsFetch     one-cycle fetch pulse to the distributor
//   CTRLWEI_ValWei       weight set valid towards the PEC array
//   CTRLWEI_CntBlk       index of the block being fetched/served
//   CTRLWEI_Busy         controller not idle
//   CTRLWEI_Done         one-cycle end-of-layer pulse
//   CTRLWEI_Err          sticky ready-watchdog error
module ctrl_wei #(
  parameter int BLK_W     = 16,
  parameter int REP_W     = 8,
  parameter int PRIME_NUM = 2,
  parameter int PRIME_GAP = 4,
  parameter int TMO_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             TOP_Start,
  input  logic [BLK_W-1:0] TOP_NumBlk,
  input  logic [REP_W-1:0] TOP_NumRep,
  input  logic             DISWEI_RdyWei,
  input  logic             PEC_ReqWei,
  output logic             CTRLWEI_PlsFetch,
  output logic             CTRLWEI_ValWei,
  output logic [BLK_W-1:0] CTRLWEI_CntBlk,
  output logic             CTRLWEI_Busy,
  output logic             CTRLWEI_Done,
  output logic             CTRLWEI_Err
);

  localparam int GAP_W = (PRIME_GAP > 2) ? $clog2(PRIME_GAP) : 1;
  localparam int PN_W  = (PRIME_NUM > 0) ? $clog2(PRIME_NUM + 1) : 1;
  // Last watchdog count value: reached in the (2**TMO_W-1)-th WAIT_RDY cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  // The fetch pulse is registered on entry to FETCH, so the pulse cycle is also
  // the one cycle in which the stale ready flag is ignored; ValWei can therefore
  // rise two cycles after a pulse.
  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FETCH,
    WAIT_RDY,
    SERVE,
    DONE
  } state_t;

  state_t state, state_n;

  logic             pls_q, pls_n;
  logic             val_q, val_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             busy_q;
  logic [BLK_W-1:0] cnt_q, cnt_n;
  logic [BLK_W-1:0] nblk_q, nblk_n;
  logic [REP_W-1:0] rep_q, rep_n;
  logic [REP_W-1:0] rlast_q, rlast_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [PN_W-1:0]  prm_q, prm_n;
  logic [TMO_W-1:0] tmo_q, tmo_n;

  always_comb begin
    state_n = state;
    pls_n   = 1'b0;
    val_n   = val_q;
    done_n  = 1'b0;
    err_n   = err_q;
    cnt_n   = cnt_q;
    nblk_n  = nblk_q;
    rep_n   = rep_q;
    rlast_n = rlast_q;
    gap_n   = gap_q;
    prm_n   = prm_q;
    tmo_n   = tmo_q;
    case (state)
      IDLE: begin
        if (TOP_Start) begin
          nblk_n  = TOP_NumBlk;
          // A reuse count of 0 behaves as 1; store the last handshake index.
          rlast_n = (TOP_NumRep == '0) ? '0 : TOP_NumRep - REP_W'(1);
          err_n   = 1'b0;
          cnt_n   = '0;
          rep_n   = '0;
          gap_n   = '0;
          prm_n   = PN_W'(1);
          tmo_n   = '0;
          if (TOP_NumBlk == '0) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            pls_n   = 1'b1;
            state_n = (PRIME_NUM == 0) ? FETCH : PRIME;
          end
        end
      end
      PRIME: begin
        // prm_q counts pulses already issued; the pulse after the last priming
        // pulse is the first real fetch.
        if (gap_q == GAP_W'(PRIME_GAP - 1)) begin
          gap_n = '0;
          pls_n = 1'b1;
          if (prm_q == PN_W'(PRIME_NUM)) begin
            state_n = FETCH;
          end else begin
            prm_n = prm_q + PN_W'(1);
          end
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end
      FETCH: begin
        tmo_n   = '0;
        state_n = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (DISWEI_RdyWei) begin
          val_n   = 1'b1;
          rep_n   = '0;
          state_n = SERVE;
        end else if (tmo_q == TMO_LAST) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end
      SERVE: begin
        // ValWei is high for the whole of SERVE, so a request is a handshake.
        if (PEC_ReqWei) begin
          if (rep_q == rlast_q) begin
            val_n = 1'b0;
            rep_n = '0;
            if (cnt_q < nblk_q - BLK_W'(1)) begin
              cnt_n   = cnt_q + BLK_W'(1);
              pls_n   = 1'b1;
              state_n = FETCH;
            end else begin
              done_n  = 1'b1;
              state_n = DONE;
            end
          end else begin
            rep_n = rep_q + REP_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pls_q   <= 1'b0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      nblk_q  <= '0;
      rep_q   <= '0;
      rlast_q <= '0;
      gap_q   <= '0;
      prm_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state   <= state_n;
      pls_q   <= pls_n;
      val_q   <= val_n;
      done_q  <= done_n;
      err_q   <= err_n;
      busy_q  <= (state_n != IDLE);
      cnt_q   <= cnt_n;
      nblk_q  <= nblk_n;
      rep_q   <= rep_n;
      rlast_q <= rlast_n;
      gap_q   <= gap_n;
      prm_q   <= prm_n;
      tmo_q   <= tmo_n;
    end
  end

  assign CTRLWEI_PlsFetch = pls_q;
  assign CTRLWEI_ValWei   = val_q;
  assign CTRLWEI_CntBlk   = cnt_q;
  assign CTRLWEI_Busy     = busy_q;
  assign CTRLWEI_Done     = done_q;
  assign CTRLWEI_Err      = err_q;

endmodule
